rgb_sum_divider: RTL and testbench
==================================

RGB_SUM_DIVIDER -- requirements
Module: rgb_sum_divider

Interface
REQ-001 SHALL have parameter DW, default 22, meaning dividend/quotient width (the accumulated RGB channel sum).
REQ-002 SHALL have parameter VW, default 14, meaning divisor/remainder width (the pixel count).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to divide; sampled only in IDLE.
REQ-006 SHALL have port dividend  input  DW  accumulated sum; captured when start is accepted.
REQ-007 SHALL have port divisor  input  VW  pixel count; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse: results are valid.
REQ-010 SHALL have port quotient  output  DW  result; held from done until the next accepted start.
REQ-011 SHALL have port remainder  output  VW  result; held with quotient.
REQ-012 SHALL have port div_by_zero  output  1  flag: the last accepted divisor was 0; held with quotient.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-014 SHALL accept start only in IDLE: latch the operands, clear the iteration counter and all result outputs, set busy, and go to CALC.
REQ-015 SHALL go from IDLE directly to DONE when the latched divisor is 0 (zero check taken from the captured divisor).
REQ-016 SHALL perform restoring shift-subtract division in CALC, one quotient bit per cycle, MSB first, using a VW+1-bit partial remainder.
REQ-017 SHALL use a ceil(log2(DW))-bit counter in CALC and go to DONE after exactly DW iterations.
REQ-018 SHALL assert done in the single DONE cycle, drive quotient and remainder there, deassert busy, and return to IDLE next cycle.
REQ-019 SHALL give a latency, for a nonzero divisor, of DW+1 cycles from the start-accept edge to the edge on which done is seen high.
REQ-020 SHALL produce, for a zero divisor, quotient = all ones, remainder = 0 and div_by_zero = 1, with done one cycle after accept.
REQ-021 SHALL ignore start while busy or in DONE, with no effect on operands or results.
REQ-022 SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor (without rounding).

Reset
REQ-023 SHALL, while rst_n is low, force the FSM to IDLE and drive busy, done, quotient, remainder, div_by_zero and the counter to 0 without waiting for a clock edge.
REQ-024 SHALL, on reset mid-CALC, abandon the operation: no done pulse, and the next start begins a fresh division.

Configuration
REQ-025 SHALL, when macro RGB_DIV_ROUND_EN is defined, round the quotient to nearest in the DONE cycle: add 1 when 2*remainder >= divisor, saturating at all ones, with remainder still reported unrounded and latency unchanged.
REQ-026 SHALL, when RGB_DIV_ROUND_EN is undefined, produce a truncated quotient and contain no rounding logic.

Structure
REQ-027 SHALL place the FSM state enum and the default DW and VW constants in shared package rgb_div_pkg.
REQ-028 SHALL implement one iteration in combinational sub-module div_sub_step: inputs partial remainder, next dividend bit and divisor; outputs next partial remainder and quotient bit.

Verification
REQ-029 Bench SHALL check: dividend=1000, divisor=10 -> done 23 cycles after accept, quotient=100, remainder=0, div_by_zero=0.
REQ-030 Bench SHALL check: dividend=4194303, divisor=16383 -> quotient=256, remainder=255.
REQ-031 Bench SHALL check: divisor=0, dividend=5 -> done 1 cycle after accept, quotient=4194303, remainder=0, div_by_zero=1.
REQ-032 Bench SHALL check: second start pulsed at cycle 5 of CALC with different operands -> ignored; first result delivered unchanged at cycle 23.
REQ-033 Bench SHALL check: rst_n low at CALC cycle 10 -> outputs 0 immediately, no done; a fresh 1000/10 then gives 100 after 23 cycles.
REQ-034 Bench SHALL check: 25/10 -> quotient 2 (macro off) or 3 (macro on); 24/10 -> 2 either way; remainder reported as 5 and 4 respectively.

Source files
------------

// File: rtl/rgb_div_pkg.sv
// rgb_div_pkg -- shared definitions for the RGB channel-sum divider.
//   div_state_t : divider FSM state encoding (IDLE, CALC, DONE)
//   DEF_DW      : default dividend/quotient width (accumulated channel sum)
//   DEF_VW      : default divisor/remainder width (pixel count)
package rgb_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DEF_DW = 22;
   localparam int DEF_VW = 14;

endpackage

// File: rtl/div_sub_step.sv
// div_sub_step -- one restoring shift-subtract division iteration (combinational).
// Ports:
//   rem_in  : current partial remainder (always < divisor)
//   bit_in  : next dividend bit, MSB first
//   divisor : divisor
//   rem_out : next partial remainder
//   q_bit   : quotient bit produced by this iteration
module div_sub_step #(
   parameter int VW = 14
) (
   input  logic [VW-1:0] rem_in,
   input  logic          bit_in,
   input  logic [VW-1:0] divisor,
   output logic [VW-1:0] rem_out,
   output logic          q_bit
);

   // The shifted-in trial value needs one extra bit; after a successful
   // subtract (or a restore) it is back below the divisor and fits in VW bits.
   logic [VW:0] trial;

   assign trial   = {rem_in, bit_in};
   assign q_bit   = (trial >= {1'b0, divisor});
   assign rem_out = q_bit ? VW'(trial - {1'b0, divisor}) : trial[VW-1:0];

endmodule

// File: rtl/rgb_sum_divider.sv
// rgb_sum_divider -- sequential divider turning an accumulated RGB channel sum
// into a per-pixel mean: one quotient bit per clock, DW+1 cycles start-to-done.
// Optional build macro: RGB_DIV_ROUND_EN -- round quotient to nearest
// (saturating); remainder always reported unrounded.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : division request, accepted only in IDLE
//   dividend     : channel sum, captured on accept
//   divisor      : pixel count, captured on accept
//   busy         : division in progress
//   done         : one-cycle result-valid pulse
//   quotient     : result, held until the next accepted start
//   remainder    : result remainder, held with quotient
//   div_by_zero  : last accepted divisor was zero
module rgb_sum_divider
   import rgb_div_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int VW = DEF_VW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   div_state_t    state, state_nx;
   logic [CW-1:0] cnt;
   logic [DW-1:0] dvd;      // dividend bits leave at the MSB, quotient bits enter at the LSB
   logic [VW-1:0] dsr;
   logic [VW-1:0] prem;
   logic [VW-1:0] prem_nx;
   logic          qbit;
   logic          last;
   logic [DW-1:0] q_fin;
   logic [DW-1:0] q_out;

   div_sub_step #(.VW(VW)) u_step (
      .rem_in  (prem),
      .bit_in  (dvd[DW-1]),
      .divisor (dsr),
      .rem_out (prem_nx),
      .q_bit   (qbit)
   );

   assign last  = (cnt == CW'(DW - 1));
   assign q_fin = {dvd[DW-2:0], qbit};

`ifdef RGB_DIV_ROUND_EN
   logic round_up;
   // 2*r >= d, compared one bit wider so the doubled remainder cannot overflow
   assign round_up = ({prem_nx, 1'b0} >= {1'b0, dsr});
   assign q_out    = (round_up && !(&q_fin)) ? q_fin + 1'b1 : q_fin;
`else
   assign q_out    = q_fin;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (divisor == '0) ? DONE : CALC;
         CALC:    if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == CALC);
   assign done = (state == DONE);

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         dvd         <= '0;
         dsr         <= '0;
         prem        <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               dvd         <= dividend;
               dsr         <= divisor;
               prem        <= '0;
               cnt         <= '0;
               remainder   <= '0;
               // A zero divisor skips CALC, so its fixed result is loaded here.
               quotient    <= (divisor == '0) ? '1 : '0;
               div_by_zero <= (divisor == '0);
            end
            CALC: begin
               dvd  <= q_fin;
               prem <= prem_nx;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  quotient  <= q_out;
                  remainder <= prem_nx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_sum_divider.sv
// tb_rgb_sum_divider -- self-checking bench for rgb_sum_divider: fixed vector
// table, start-while-busy and mid-calculation reset sequences, then random
// operands checked against a plain-arithmetic reference.
module tb_rgb_sum_divider;

   localparam int DW = 22;
   localparam int VW = 14;
`ifdef RGB_DIV_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] dividend = '0;
   logic [VW-1:0] divisor = '0;
   logic          busy, done, div_by_zero;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;

   rgb_sum_divider #(.DW(DW), .VW(VW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int errs  = 0;

   typedef struct {
      longint a;
      longint b;
      longint q;
      longint r;
      longint z;
      int     lat;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input longint a, input longint b, input longint q,
                               input longint r, input longint z, input int lat);
      vec_t v;
      v.a = a; v.b = b; v.q = q; v.r = r; v.z = z; v.lat = lat;
      return v;
   endfunction

   // Reference: integer division, optional round-half-up with saturation.
   function automatic vec_t model(input longint a, input longint b);
      vec_t   v;
      longint qmax;
      qmax = (64'd1 << DW) - 1;
      v.a = a; v.b = b;
      if (b == 0) begin
         v.q = qmax; v.r = 0; v.z = 1; v.lat = 1;
      end else begin
         v.q = a / b; v.r = a % b; v.z = 0; v.lat = DW + 1;
         if (RND && (2 * v.r >= b) && (v.q < qmax)) v.q = v.q + 1;
      end
      return v;
   endfunction

   // Issue one start and follow it to done. inject_at>0 pulses a second start
   // with different operands at that CALC cycle.
   task automatic run(input vec_t v, input string nm, input int inject_at);
      int lat;
      bit seen;
      @(negedge clk);
      dividend = v.a[DW-1:0];
      divisor  = v.b[VW-1:0];
      start    = 1'b1;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 60) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (lat == 1 && v.lat > 1) begin
            chk({nm, " busy"}, busy, 1);
            chk({nm, " quotient cleared"}, quotient, 0);
         end
         if (inject_at > 0 && lat == inject_at) begin
            dividend = 22'd77;
            divisor  = 14'd3;
            start    = 1'b1;
         end
         if (done) seen = 1'b1;
      end
      chk({nm, " latency"}, seen ? lat : -1, v.lat);
      chk({nm, " quotient"}, quotient, v.q);
      chk({nm, " remainder"}, remainder, v.r);
      chk({nm, " div_by_zero"}, div_by_zero, v.z);
      chk({nm, " busy at done"}, busy, 0);
      @(negedge clk);
      chk({nm, " done pulse width"}, done, 0);
      chk({nm, " quotient held"}, quotient, v.q);
   endtask

   initial begin
      vec_t v;
      int   sel;
      longint a, b;

      vt.push_back(mk(1000, 10, 100, 0, 0, DW + 1));
      vt.push_back(mk(4194303, 16383, 256, 255, 0, DW + 1));
      vt.push_back(mk(5, 0, 4194303, 0, 1, 1));
      vt.push_back(mk(25, 10, RND ? 3 : 2, 5, 0, DW + 1));
      vt.push_back(mk(24, 10, 2, 4, 0, DW + 1));
      vt.push_back(mk(4194303, 1, 4194303, 0, 0, DW + 1));
      vt.push_back(mk(0, 7, 0, 0, 0, DW + 1));
      vt.push_back(mk(4194303, 2, RND ? 2097152 : 2097151, 1, 0, DW + 1));
      vt.push_back(mk(3, 16383, 0, 3, 0, DW + 1));

      // Reset state, asserted asynchronously from time zero
      #1;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset quotient", quotient, 0);
      chk("reset remainder", remainder, 0);
      chk("reset div_by_zero", div_by_zero, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++)
         run(vt[i], $sformatf("vec%0d", i), 0);

      // Start pulsed during CALC must be ignored
      run(mk(1000, 10, 100, 0, 0, DW + 1), "start-while-busy", 5);

      // Reset at CALC cycle 10 abandons the division immediately
      @(negedge clk);
      dividend = 22'd1000;
      divisor  = 14'd10;
      start    = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("pre-reset busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid-reset busy", busy, 0);
      chk("mid-reset done", done, 0);
      chk("mid-reset quotient", quotient, 0);
      chk("mid-reset remainder", remainder, 0);
      chk("mid-reset div_by_zero", div_by_zero, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("done during reset", done, 0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         chk("no done after abandoned op", done, 0);
      end
      run(mk(1000, 10, 100, 0, 0, DW + 1), "after-reset", 0);

      // Random operands against the reference
      for (int i = 0; i < 24; i++) begin
         a   = $urandom_range(0, (1 << DW) - 1);
         sel = $urandom_range(0, 3);
         if (sel == 0)      b = 0;
         else if (sel == 1) b = $urandom_range(1, 15);
         else               b = $urandom_range(1, (1 << VW) - 1);
         v = model(a, b);
         run(v, $sformatf("rand%0d %0d/%0d", i, a, b), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule
